// File: rtl/regfile_io_writer.sv
// ============================================================================
// regfile_io_writer : merges CPU writeback and buffered peripheral writes into
// one registered register-file write port. Optional: REGFILE_IO_STARVE_GUARD_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_io_writer #(
  parameter int          DEPTH        = 4,
  parameter logic [31:0] ALLOW_MASK   = 32'h3ED00000,
  parameter int          STARVE_LIMIT = 8
) (
  input  logic                     clock,
  input  logic                     ctrl_reset_n,
  input  logic                     cpu_writeEnable,
  input  logic [4:0]               cpu_writeReg,
  input  logic [31:0]              cpu_data,
  input  logic                     per_valid,
  input  logic [4:0]               per_reg,
  input  logic [31:0]              per_data,
  output logic                     per_ready,
  output logic                     ctrl_writeEnable,
  output logic [4:0]               ctrl_writeReg,
  output logic [31:0]              data_writeReg,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     err_sticky,
  output logic                     cpu_stall
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   C_FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

  logic [4:0]    r_mem_reg  [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;

  logic w_push;
  logic w_allowed;
  logic w_enq;
  logic w_pop;

  assign per_ready  = (r_count != C_FULL);
  assign fifo_count = r_count;
  assign w_push     = per_valid && per_ready;
  // Register 0 is never a legal peripheral target regardless of the mask.
  assign w_allowed  = ALLOW_MASK[per_reg] && (per_reg != 5'd0);
  assign w_enq      = w_push && w_allowed;
  assign w_pop      = !cpu_writeEnable && (r_count != '0);

  always_ff @(posedge clock) begin
    if (w_enq) begin
      r_mem_reg[r_wr_ptr]  <= per_reg;
      r_mem_data[r_wr_ptr] <= per_data;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_rd_ptr         <= '0;
      r_wr_ptr         <= '0;
      r_count          <= '0;
      err_sticky       <= 1'b0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_push && !w_allowed) begin
        err_sticky <= 1'b1;
      end
      // Processor always wins; address/data hold when nothing is selected.
      if (cpu_writeEnable) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= cpu_writeReg;
        data_writeReg    <= cpu_data;
      end else if (w_pop) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= r_mem_reg[r_rd_ptr];
        data_writeReg    <= r_mem_data[r_rd_ptr];
      end else begin
        ctrl_writeEnable <= 1'b0;
      end
    end
  end

`ifdef REGFILE_IO_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] C_STARVE_LAST = SW'(STARVE_LIMIT - 1);
  localparam logic [SW-1:0] C_STARVE_ONE  = SW'(1);

  logic [SW-1:0] r_starve_cnt;
  logic          r_stall;
  logic          w_blocked;

  assign w_blocked = cpu_writeEnable && (r_count != '0);
  assign cpu_stall = r_stall;

  // The stall cycle itself always restarts the run, whether or not the CPU obeyed.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_starve_cnt <= '0;
      r_stall      <= 1'b0;
    end else if (r_stall) begin
      r_starve_cnt <= '0;
      r_stall      <= 1'b0;
    end else if (w_blocked) begin
      if (r_starve_cnt == C_STARVE_LAST) begin
        r_starve_cnt <= '0;
        r_stall      <= 1'b1;
      end else begin
        r_starve_cnt <= r_starve_cnt + C_STARVE_ONE;
      end
    end else begin
      r_starve_cnt <= '0;
    end
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign cpu_stall           = 1'b0;
`endif

endmodule

`default_nettype wire
